moldudp64_seq_tracker: RTL and testbench

MOLDUDP64_SEQ_TRACKER -- requirements
Module: moldudp64_seq_tracker

---
 rtl/moldudp64_seq_tracker.sv | 243 ++++++++++++++++++++++++
 tb/tb_moldudp64_seq_tracker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/moldudp64_seq_tracker.sv
`default_nettype none
// ============================================================================
// Module   : moldudp64_seq_tracker
// Purpose  : Per-channel MoldUDP64 sequence tracker: dedup, gap and EOS
//            detection, plus a heartbeat-timeout flag for each channel.
// Revision : 1.0 - initial release
// ============================================================================
module moldudp64_seq_tracker #(
    parameter int              CH_N        = 2,
    parameter int              CH_W        = 1,
    parameter int              SID_W       = 80,
    parameter int              SEQ_NUM_W   = 64,
    parameter int              ML_W        = 16,
    parameter logic [ML_W-1:0] EOS_MSG_CNT = 16'hFFFF,
    parameter int              HB_TO_W     = 16,
    parameter int              HB_TO       = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hdr_v_i,
    output logic                 hdr_ready_o,
    input  logic [CH_W-1:0]      hdr_ch_i,
    input  logic [SID_W-1:0]     hdr_sid_i,
    input  logic [SEQ_NUM_W-1:0] hdr_seq_num_i,
    input  logic [ML_W-1:0]      hdr_msg_cnt_i,
    output logic                 res_v_o,
    input  logic                 res_ready_i,
    output logic [CH_W-1:0]      res_ch_o,
    output logic [ML_W-1:0]      res_skip_o,
    output logic [ML_W-1:0]      res_new_o,
    output logic                 res_resync_o,
    output logic                 res_eos_o,
    output logic                 miss_v_o,
    output logic [SEQ_NUM_W-1:0] miss_start_o,
    output logic [SEQ_NUM_W-1:0] miss_cnt_o,
    output logic [CH_N-1:0]      flatlined_o
);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_SYNC   = 2'd1,
        ST_EOS    = 2'd2
    } ch_state_t;

    localparam logic [HB_TO_W-1:0] HB_MAX = HB_TO_W'(HB_TO);

    ch_state_t            state_q [CH_N];
    ch_state_t            state_d [CH_N];
    logic [SEQ_NUM_W-1:0] exp_q   [CH_N];
    logic [SEQ_NUM_W-1:0] exp_d   [CH_N];
    logic [SID_W-1:0]     sid_q   [CH_N];
    logic [SID_W-1:0]     sid_d   [CH_N];
    logic [HB_TO_W-1:0]   hb_q    [CH_N];
    logic [HB_TO_W-1:0]   hb_d    [CH_N];

    logic                 res_v_q, res_v_d;
    logic [CH_W-1:0]      res_ch_q, res_ch_d;
    logic [ML_W-1:0]      res_skip_q, res_skip_d;
    logic [ML_W-1:0]      res_new_q, res_new_d;
    logic                 res_resync_q, res_resync_d;
    logic                 res_eos_q, res_eos_d;
    logic                 miss_v_q, miss_v_d;
    logic [SEQ_NUM_W-1:0] miss_start_q, miss_start_d;
    logic [SEQ_NUM_W-1:0] miss_cnt_q, miss_cnt_d;

    logic                 hdr_acc;
    logic                 ch_valid;
    ch_state_t            cur_state;
    logic [SEQ_NUM_W-1:0] cur_exp;
    logic [SID_W-1:0]     cur_sid;
    logic [SEQ_NUM_W-1:0] seq_end;
    logic                 is_ctl;

    ch_state_t            nx_state;
    logic [SEQ_NUM_W-1:0] nx_exp;
    logic [SID_W-1:0]     nx_sid;
    logic [ML_W-1:0]      c_skip, c_new;
    logic                 c_resync, c_eos, c_miss;
    logic [SEQ_NUM_W-1:0] c_miss_start, c_miss_cnt;

    assign hdr_ready_o = ~res_v_q | res_ready_i;
    assign hdr_acc     = hdr_v_i & hdr_ready_o;
    assign seq_end     = hdr_seq_num_i + SEQ_NUM_W'(hdr_msg_cnt_i);
    // Heartbeats and end-of-session markers carry no payload messages.
    assign is_ctl      = (hdr_msg_cnt_i == '0) || (hdr_msg_cnt_i == EOS_MSG_CNT);

    always_comb begin
        ch_valid  = 1'b0;
        cur_state = ST_UNSYNC;
        cur_exp   = '0;
        cur_sid   = '0;
        for (int i = 0; i < CH_N; i++) begin
            if (hdr_ch_i == CH_W'(i)) begin
                ch_valid  = 1'b1;
                cur_state = state_q[i];
                cur_exp   = exp_q[i];
                cur_sid   = sid_q[i];
            end
        end
    end

    always_comb begin
        nx_state     = cur_state;
        nx_exp       = cur_exp;
        nx_sid       = cur_sid;
        c_skip       = '0;
        c_new        = '0;
        c_resync     = 1'b0;
        c_eos        = 1'b0;
        c_miss       = 1'b0;
        c_miss_start = '0;
        c_miss_cnt   = '0;
        if (cur_state == ST_UNSYNC || hdr_sid_i != cur_sid) begin
            nx_state = ST_SYNC;
            nx_sid   = hdr_sid_i;
            nx_exp   = seq_end;
            c_new    = hdr_msg_cnt_i;
            c_resync = 1'b1;
        end else if (cur_state == ST_EOS) begin
            c_eos = 1'b1;
        end else begin
            if (hdr_seq_num_i > cur_exp) begin
                c_miss       = 1'b1;
                c_miss_start = cur_exp;
                c_miss_cnt   = hdr_seq_num_i - cur_exp;
            end
            if (is_ctl) begin
                if (hdr_seq_num_i > cur_exp) begin
                    nx_exp = hdr_seq_num_i;
                end
                if (hdr_msg_cnt_i == EOS_MSG_CNT) begin
                    c_eos    = 1'b1;
                    nx_state = ST_EOS;
                end
            end else if (hdr_seq_num_i >= cur_exp) begin
                c_new  = hdr_msg_cnt_i;
                nx_exp = seq_end;
            end else if (seq_end <= cur_exp) begin
                c_skip = hdr_msg_cnt_i;
            end else begin
                // Straddles the expected number: drop the already-seen head.
                c_skip = ML_W'(cur_exp - hdr_seq_num_i);
                c_new  = ML_W'(seq_end - cur_exp);
                nx_exp = seq_end;
            end
        end
    end

    always_comb begin
        res_v_d      = res_v_q;
        res_ch_d     = res_ch_q;
        res_skip_d   = res_skip_q;
        res_new_d    = res_new_q;
        res_resync_d = res_resync_q;
        res_eos_d    = res_eos_q;
        miss_v_d     = miss_v_q;
        miss_start_d = miss_start_q;
        miss_cnt_d   = miss_cnt_q;
        for (int i = 0; i < CH_N; i++) begin
            state_d[i] = state_q[i];
            exp_d[i]   = exp_q[i];
            sid_d[i]   = sid_q[i];
            if (hdr_acc && hdr_ch_i == CH_W'(i)) begin
                state_d[i] = nx_state;
                exp_d[i]   = nx_exp;
                sid_d[i]   = nx_sid;
                hb_d[i]    = '0;
            end else if (hb_q[i] != HB_MAX) begin
                hb_d[i] = hb_q[i] + 1'b1;
            end else begin
                hb_d[i] = hb_q[i];
            end
        end
        if (hdr_acc && ch_valid) begin
            res_v_d      = 1'b1;
            res_ch_d     = hdr_ch_i;
            res_skip_d   = c_skip;
            res_new_d    = c_new;
            res_resync_d = c_resync;
            res_eos_d    = c_eos;
            miss_v_d     = c_miss;
            miss_start_d = c_miss_start;
            miss_cnt_d   = c_miss_cnt;
        end else if (res_ready_i) begin
            res_v_d  = 1'b0;
            miss_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH_N; i++) begin
                state_q[i] <= ST_UNSYNC;
                exp_q[i]   <= '0;
                sid_q[i]   <= '0;
                hb_q[i]    <= '0;
            end
            res_v_q      <= 1'b0;
            res_ch_q     <= '0;
            res_skip_q   <= '0;
            res_new_q    <= '0;
            res_resync_q <= 1'b0;
            res_eos_q    <= 1'b0;
            miss_v_q     <= 1'b0;
            miss_start_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            for (int i = 0; i < CH_N; i++) begin
                state_q[i] <= state_d[i];
                exp_q[i]   <= exp_d[i];
                sid_q[i]   <= sid_d[i];
                hb_q[i]    <= hb_d[i];
            end
            res_v_q      <= res_v_d;
            res_ch_q     <= res_ch_d;
            res_skip_q   <= res_skip_d;
            res_new_q    <= res_new_d;
            res_resync_q <= res_resync_d;
            res_eos_q    <= res_eos_d;
            miss_v_q     <= miss_v_d;
            miss_start_q <= miss_start_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    generate
        for (genvar g = 0; g < CH_N; g++) begin : g_flat
            assign flatlined_o[g] = (hb_q[g] == HB_MAX);
        end
    endgenerate

    assign res_v_o      = res_v_q;
    assign res_ch_o     = res_ch_q;
    assign res_skip_o   = res_skip_q;
    assign res_new_o    = res_new_q;
    assign res_resync_o = res_resync_q;
    assign res_eos_o    = res_eos_q;
    assign miss_v_o     = miss_v_q;
    assign miss_start_o = miss_start_q;
    assign miss_cnt_o   = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_moldudp64_seq_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_moldudp64_seq_tracker
// Purpose  : Directed plus randomized bench for moldudp64_seq_tracker against
//            a session-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_moldudp64_seq_tracker;

    localparam logic [79:0] SID_A = 80'hDEADBEEF;
    localparam logic [79:0] SID_B = 80'hCAFE;
    localparam int          TO    = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hdr_v_i = 1'b0;
    logic        hdr_ready_o;
    logic [1:0]  hdr_ch_i = '0;
    logic [79:0] hdr_sid_i = '0;
    logic [63:0] hdr_seq_num_i = '0;
    logic [15:0] hdr_msg_cnt_i = '0;
    logic        res_v_o;
    logic        res_ready_i = 1'b0;
    logic [1:0]  res_ch_o;
    logic [15:0] res_skip_o, res_new_o;
    logic        res_resync_o, res_eos_o, miss_v_o;
    logic [63:0] miss_start_o, miss_cnt_o;
    logic [1:0]  flatlined_o;

    moldudp64_seq_tracker #(
        .CH_N(2), .CH_W(2), .SID_W(80), .SEQ_NUM_W(64), .ML_W(16),
        .EOS_MSG_CNT(16'hFFFF), .HB_TO_W(16), .HB_TO(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .hdr_v_i(hdr_v_i), .hdr_ready_o(hdr_ready_o),
        .hdr_ch_i(hdr_ch_i), .hdr_sid_i(hdr_sid_i),
        .hdr_seq_num_i(hdr_seq_num_i), .hdr_msg_cnt_i(hdr_msg_cnt_i),
        .res_v_o(res_v_o), .res_ready_i(res_ready_i), .res_ch_o(res_ch_o),
        .res_skip_o(res_skip_o), .res_new_o(res_new_o),
        .res_resync_o(res_resync_o), .res_eos_o(res_eos_o),
        .miss_v_o(miss_v_o), .miss_start_o(miss_start_o), .miss_cnt_o(miss_cnt_o),
        .flatlined_o(flatlined_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: session knowledge per channel plus the pending result.
    bit          m_sync [2];
    bit          m_ended [2];
    logic [63:0] m_exp [2];
    logic [79:0] m_sid [2];
    int          m_last [2];
    int          n_cyc;
    bit          m_res_v, m_resync, m_eos, m_miss;
    logic [1:0]  m_ch;
    logic [15:0] m_skip, m_new;
    logic [63:0] m_mstart, m_mcnt;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_sync[c] = 0; m_ended[c] = 0; m_exp[c] = '0; m_sid[c] = '0; m_last[c] = 0;
        end
        n_cyc = 0; m_res_v = 0;
    endtask

    task automatic model_edge(input bit v, input logic [1:0] ch, input logic [79:0] sid,
                              input logic [63:0] seq, input logic [15:0] cnt, input bit rdy);
        bit          acc;
        int          c;
        logic [63:0] e, last_msg;
        acc = v && (!m_res_v || rdy);
        if (acc && ch < 2) begin
            c = int'(ch);
            e = m_exp[c];
            last_msg = seq + 64'(cnt);
            m_last[c] = n_cyc + 1;
            m_res_v = 1; m_ch = ch; m_skip = 0; m_new = 0;
            m_resync = 0; m_eos = 0; m_miss = 0; m_mstart = 0; m_mcnt = 0;
            if (!m_sync[c] || sid != m_sid[c]) begin
                m_sync[c] = 1; m_ended[c] = 0; m_sid[c] = sid;
                m_exp[c] = last_msg; m_new = cnt; m_resync = 1;
            end else if (m_ended[c]) begin
                m_eos = 1;
            end else begin
                if (seq > e) begin
                    m_miss = 1; m_mstart = e; m_mcnt = seq - e;
                end
                if (cnt == 0 || cnt == 16'hFFFF) begin
                    if (seq > e) m_exp[c] = seq;
                    if (cnt == 16'hFFFF) begin
                        m_eos = 1; m_ended[c] = 1;
                    end
                end else if (seq >= e) begin
                    m_new = cnt; m_exp[c] = last_msg;
                end else if (last_msg <= e) begin
                    m_skip = cnt;
                end else begin
                    m_skip = 16'(e - seq); m_new = 16'(last_msg - e); m_exp[c] = last_msg;
                end
            end
        end else if (rdy) begin
            m_res_v = 0;
        end
    endtask

    task automatic compare_outputs();
        logic [1:0] flat;
        check("res_v", res_v_o, m_res_v);
        if (m_res_v) begin
            check("res_ch", res_ch_o, m_ch);
            check("res_skip", res_skip_o, m_skip);
            check("res_new", res_new_o, m_new);
            check("res_resync", res_resync_o, m_resync);
            check("res_eos", res_eos_o, m_eos);
            check("miss_v", miss_v_o, m_miss);
            if (m_miss) begin
                check("miss_start", miss_start_o, m_mstart);
                check("miss_cnt", miss_cnt_o, m_mcnt);
            end
        end
        for (int c = 0; c < 2; c++) flat[c] = (n_cyc - m_last[c]) >= TO;
        check("flatlined", flatlined_o, flat);
    endtask

    // Called at posedge+1; drives inputs, advances one clock, checks at posedge+1.
    task automatic drive_cycle(input bit v, input logic [1:0] ch, input logic [79:0] sid,
                               input logic [63:0] seq, input logic [15:0] cnt, input bit rdy);
        hdr_v_i = v; hdr_ch_i = ch; hdr_sid_i = sid;
        hdr_seq_num_i = seq; hdr_msg_cnt_i = cnt; res_ready_i = rdy;
        #1;
        check("hdr_ready", hdr_ready_o, !m_res_v || rdy);
        model_edge(v, ch, sid, seq, cnt, rdy);
        @(posedge clk);
        #1;
        n_cyc++;
        compare_outputs();
    endtask

    task automatic do_reset();
        hdr_v_i = 0; res_ready_i = 0; reset = 1;
        #1;
        check("rst_async_res_v", res_v_o, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        #1;
        check("rst_res_v", res_v_o, 0);
        check("rst_miss_v", miss_v_o, 0);
        check("rst_fields", {res_skip_o, res_new_o, 14'd0, res_resync_o, res_eos_o}, 0);
        check("rst_flat", flatlined_o, 0);
        check("rst_ready", hdr_ready_o, 1);
    endtask

    initial begin
        logic [63:0] base, s;
        logic [15:0] n;
        int          c, r;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Directed session walk on channel 0.
        drive_cycle(1, 0, SID_A, 100, 3, 1);
        check("d_resync", res_resync_o, 1); check("d_new3", res_new_o, 3);
        drive_cycle(1, 0, SID_A, 103, 2, 1);
        check("d_new2", res_new_o, 2); check("d_skip0", res_skip_o, 0);
        drive_cycle(1, 0, SID_A, 110, 1, 1);
        check("d_miss_v", miss_v_o, 1); check("d_miss_start", miss_start_o, 105);
        check("d_miss_cnt", miss_cnt_o, 5); check("d_gap_new", res_new_o, 1);
        drive_cycle(1, 0, SID_A, 108, 2, 1);
        check("d_dup_skip", res_skip_o, 2); check("d_dup_new", res_new_o, 0);
        drive_cycle(1, 0, SID_A, 109, 4, 1);
        check("d_part_skip", res_skip_o, 2); check("d_part_new", res_new_o, 2);
        drive_cycle(1, 0, SID_A, 113, 16'hFFFF, 1);
        check("d_eos", res_eos_o, 1); check("d_eos_new", res_new_o, 0);
        drive_cycle(1, 0, SID_A, 200, 1, 1);
        check("d_eos_again", res_eos_o, 1); check("d_eos_nomiss", miss_v_o, 0);
        check("d_eos_new0", res_new_o, 0);
        drive_cycle(1, 0, SID_B, 300, 1, 1);
        check("d_newsid", res_resync_o, 1);

        // Out-of-range channel yields no result.
        drive_cycle(1, 2, SID_A, 5, 1, 1);
        drive_cycle(0, 0, SID_A, 0, 0, 1);
        check("d_badch", res_v_o, 0);

        // Backpressure: first result held, second header waits.
        drive_cycle(1, 0, SID_B, 301, 2, 0);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1, 0, SID_B, 303, 1, 0);
            check("d_bp_ready", hdr_ready_o, 0); check("d_bp_hold", res_new_o, 2);
        end
        drive_cycle(1, 0, SID_B, 303, 1, 1);
        check("d_bp_second", res_new_o, 1);

        // Reset with a result pending.
        drive_cycle(1, 0, SID_B, 304, 1, 0);
        do_reset();
        drive_cycle(0, 0, SID_B, 0, 0, 0);
        drive_cycle(0, 0, SID_B, 0, 0, 1);
        check("d_rst_drop", res_v_o, 0);

        // Heartbeat timeout on idle channel 1.
        do_reset();
        for (int k = 0; k < TO; k++) drive_cycle(1, 0, SID_A, 64'(500 + k), 1, 1);
        check("d_flat1", flatlined_o, 2'b10);
        drive_cycle(1, 1, SID_A, 50, 1, 1);
        check("d_flat_clear", flatlined_o, 2'b00);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 15) c = 2 + int'($urandom_range(0, 1));
            else if (((i / 50) % 2) == 1) c = 0;
            else c = int'($urandom_range(0, 1));
            base = m_exp[c % 2];
            if (base >= 5) s = base + 64'($urandom_range(0, 10)) - 64'd5;
            else s = base + 64'($urandom_range(0, 5));
            r = int'($urandom_range(0, 11));
            if (r == 0) n = 16'd0;
            else if (r == 1) n = 16'hFFFF;
            else n = 16'($urandom_range(1, 6));
            drive_cycle($urandom_range(0, 9) < 7, 2'(c),
                        ($urandom_range(0, 7) == 0) ? SID_B : SID_A,
                        s, n, $urandom_range(0, 9) < 7);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
